// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a small single-cycle ALU.
// The result is registered and held until the consumer takes it.
module alu_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req0_op,
    input  logic [3:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [7:0]  gnt_cnt0,
    output logic [7:0]  gnt_cnt1
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        id_q, id_d;
    logic        err_q, err_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  cnt0_q, cnt0_d;
    logic [7:0]  cnt1_q, cnt1_d;

    logic        accept_ok;
    logic        gnt0, gnt1;
    logic        acc;
    logic [31:0] op_a, op_b;
    logic [3:0]  op;
    logic [31:0] alu_res;
    logic        alu_err;

    // Ready is also masked by reset so nothing handshakes during reset.
    assign accept_ok  = reset && ((state_q == IDLE) || rsp_ready);
    assign gnt0       = req0_valid && (!req1_valid || last_q);
    assign gnt1       = req1_valid && (!req0_valid || !last_q);
    assign req0_ready = accept_ok && gnt0;
    assign req1_ready = accept_ok && gnt1;
    assign acc        = req0_ready || req1_ready;

    assign op_a = req1_ready ? req1_a  : req0_a;
    assign op_b = req1_ready ? req1_b  : req0_b;
    assign op   = req1_ready ? req1_op : req0_op;

    always_comb begin
        alu_res = 32'd0;
        alu_err = 1'b0;
        case (op)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a | op_b;
            4'd3:    alu_res = op_b << op_a[4:0];
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        err_d   = err_q;
        data_d  = data_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        if (acc) begin
            state_d = RESP;
            last_d  = req1_ready;
            id_d    = req1_ready;
            err_d   = alu_err;
            data_d  = alu_res;
            if (req0_ready) cnt0_d = cnt0_q + 8'd1;
            if (req1_ready) cnt1_d = cnt1_q + 8'd1;
        end else if (state_q == RESP && rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 32'd0;
            cnt0_q  <= 8'd0;
            cnt1_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            err_q   <= err_d;
            data_q  <= data_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign gnt_cnt0  = cnt0_q;
    assign gnt_cnt1  = cnt1_q;

endmodule
